// File: rtl/joypad_pkg.sv
// Shared definitions for the NES joypad port block.
// Button bit indices, default autofire half-period, rd_cnt field width.
// No logic; imported by joypad_shifter and joypad_ports.
package joypad_pkg;

    // Bit position of each button within a port's BTN_W-wide field.
    // Bit 0 is the first bit the NES reads after a strobe.
    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_idx_e;

    // 30 Hz autofire toggle at a 25 MHz clk.
    localparam int AF_HALF_DEFAULT = 416_667;

    // Width of each per-port rd_cnt field.
    localparam int RD_CNT_W = 4;

endpackage

// File: rtl/joypad_shifter.sv
// One NES controller port: port_clk falling-edge detect, parallel-load shift register, read counter.
// Latency: reload or shift visible on data_o the cycle after the strobe/edge is sampled.
// Ports: clk, resetn, strobe, port_clk, btn_eff[BTN_W] in; data_o, rd_cnt[RD_CNT_W] out. No backpressure.
module joypad_shifter
    import joypad_pkg::*;
#(
    parameter int   BTN_W = 8,
    parameter logic FILL  = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                strobe,
    input  logic                port_clk,
    input  logic [BTN_W-1:0]    btn_eff,
    output logic                data_o,
    output logic [RD_CNT_W-1:0] rd_cnt
);

    localparam logic [RD_CNT_W-1:0] CNT_MAX = RD_CNT_W'(BTN_W);

    logic                pclk_q,  pclk_d;
    logic [BTN_W-1:0]    shift_q, shift_d;
    logic [RD_CNT_W-1:0] cnt_q,   cnt_d;
    logic                armed_q, armed_d;
    logic                fall;

    always_comb begin
        pclk_d  = port_clk;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        fall    = pclk_q & ~port_clk;

        // Strobe has priority: an edge in the same cycle is dropped.
        if (strobe) begin
            shift_d = btn_eff;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (fall && armed_q) begin
            // armed_q keeps a port silent after reset until the first
            // reload; otherwise shifting FILL into the cleared register
            // would eventually present FILL without any strobe.
            shift_d           = shift_q >> 1;
            shift_d[BTN_W-1]  = FILL;
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + RD_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pclk_q  <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            pclk_q  <= pclk_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Straight from flops: no combinational path from any input.
    assign data_o = shift_q[0];
    assign rd_cnt = cnt_q;

endmodule

// File: rtl/joypad_ports.sv
// NES joypad serial ports: merges pad/override/autofire buttons, serialises each port independently.
// Latency: one cycle from a sampled strobe or port_clk fall to data_o/rd_cnt; no backpressure.
// Ports: clk, resetn, strobe, port_clk[N], btn_pad/btn_ovr/turbo_req[N*BTN_W] in; data_o[N], rd_cnt[N*4] out.
// Build option: define JOYPAD_AUTOFIRE_EN to include the autofire divider and turbo_req gating.
module joypad_ports
    import joypad_pkg::*;
#(
    parameter int   NUM_PORTS = 2,
    parameter int   BTN_W     = 8,
    parameter logic FILL      = 1'b1,
    parameter int   AF_HALF   = AF_HALF_DEFAULT
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          strobe,
    input  logic [NUM_PORTS-1:0]          port_clk,
    input  logic [NUM_PORTS*BTN_W-1:0]    btn_pad,
    input  logic [NUM_PORTS*BTN_W-1:0]    btn_ovr,
    input  logic [NUM_PORTS*BTN_W-1:0]    turbo_req,
    output logic [NUM_PORTS-1:0]          data_o,
    output logic [NUM_PORTS*RD_CNT_W-1:0] rd_cnt
);

    logic [NUM_PORTS*BTN_W-1:0] turbo_mask;
    logic [NUM_PORTS*BTN_W-1:0] btn_eff;

`ifdef JOYPAD_AUTOFIRE_EN
    localparam int AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_HALF - 1);

    logic [AF_W-1:0] div_q,      div_d;
    logic            af_phase_q, af_phase_d;

    // Free-running divider; af_phase flips each time it wraps, so one
    // phase lasts AF_HALF cycles. Shared by every port.
    always_comb begin
        div_d      = div_q + AF_W'(1);
        af_phase_d = af_phase_q;
        if (div_q == AF_LAST) begin
            div_d      = '0;
            af_phase_d = ~af_phase_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q      <= '0;
            af_phase_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            af_phase_q <= af_phase_d;
        end
    end

    assign turbo_mask = turbo_req & {(NUM_PORTS*BTN_W){af_phase_q}};
`else
    logic unused_turbo_req;
    assign unused_turbo_req = ^turbo_req;
    assign turbo_mask       = '0;
`endif

    assign btn_eff = btn_pad | btn_ovr | turbo_mask;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        joypad_shifter #(
            .BTN_W (BTN_W),
            .FILL  (FILL)
        ) u_shifter (
            .clk      (clk),
            .resetn   (resetn),
            .strobe   (strobe),
            .port_clk (port_clk[p]),
            .btn_eff  (btn_eff[p*BTN_W +: BTN_W]),
            .data_o   (data_o[p]),
            .rd_cnt   (rd_cnt[p*RD_CNT_W +: RD_CNT_W])
        );
    end

endmodule

// File: tb/tb_joypad_ports.sv
`timescale 1ns/1ps
module tb_joypad_ports;
    import joypad_pkg::*;

    localparam int   NP    = 2;
    localparam int   BW    = 8;
    localparam int   AF    = 4;
    localparam logic FILLV = 1'b1;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           strobe = 1'b0;
    logic [NP-1:0]  port_clk = '0;
    logic [NP*BW-1:0] btn_pad = '0, btn_ovr = '0, turbo_req = '0;
    logic [NP-1:0]  data_o;
    logic [NP*4-1:0] rd_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    joypad_ports #(
        .NUM_PORTS (NP),
        .BTN_W     (BW),
        .FILL      (FILLV),
        .AF_HALF   (AF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .strobe    (strobe),
        .port_clk  (port_clk),
        .btn_pad   (btn_pad),
        .btn_ovr   (btn_ovr),
        .turbo_req (turbo_req),
        .data_o    (data_o),
        .rd_cnt    (rd_cnt)
    );

    // Reference model: each port remembers the button byte latched at the
    // last strobe and how many bits the NES has consumed since then.
    logic [BW-1:0] m_lat   [NP];
    int            m_idx   [NP];
    bit            m_armed [NP];
    bit            m_prev  [NP];
    int            m_cyc;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < NP; p++) begin
                m_lat[p] = '0; m_idx[p] = 0; m_armed[p] = 0; m_prev[p] = 0;
            end
            m_cyc = 0;
        end else begin
            bit            ph;
            bit            fall;
            logic [BW-1:0] eff;
            ph = 0;
`ifdef JOYPAD_AUTOFIRE_EN
            ph = ((m_cyc / AF) % 2) == 1;
`endif
            m_cyc++;
            for (int p = 0; p < NP; p++) begin
                eff = btn_pad[p*BW +: BW] | btn_ovr[p*BW +: BW] |
                      (ph ? turbo_req[p*BW +: BW] : '0);
                fall = m_prev[p] && !port_clk[p];
                m_prev[p] = port_clk[p];
                if (strobe) begin
                    m_lat[p] = eff; m_idx[p] = 0; m_armed[p] = 1;
                end else if (fall && m_armed[p] && m_idx[p] < BW) begin
                    m_idx[p]++;
                end
            end
        end
    end

    function automatic logic exp_dat(int p);
        if (!m_armed[p]) return 1'b0;
        if (m_idx[p] < BW) return m_lat[p][m_idx[p]];
        return FILLV;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int p = 0; p < NP; p++) begin
            check($sformatf("model_dat_p%0d", p), 32'(data_o[p]), 32'(exp_dat(p)));
            check($sformatf("model_cnt_p%0d", p), 32'(rd_cnt[p*4 +: 4]), 32'(m_idx[p]));
        end
    endtask

    // Inputs change just after a falling edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_pclk(input int p);
        port_clk[p] = 1'b1; step();
        port_clk[p] = 1'b0; step();
    endtask

    task automatic strobe_pulse();
        strobe = 1'b1; step();
        strobe = 1'b0;
    endtask

    typedef struct {
        int         edges;
        logic       dat;
        logic [3:0] cnt;
    } vec_t;
    vec_t tbl [11];

    int ones;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Read-out of 8'b1000_0101 on port 0, then FILL.
        tbl[0]  = '{0,  1'b1, 4'd0};
        tbl[1]  = '{1,  1'b0, 4'd1};
        tbl[2]  = '{2,  1'b1, 4'd2};
        tbl[3]  = '{3,  1'b0, 4'd3};
        tbl[4]  = '{4,  1'b0, 4'd4};
        tbl[5]  = '{5,  1'b0, 4'd5};
        tbl[6]  = '{6,  1'b0, 4'd6};
        tbl[7]  = '{7,  1'b1, 4'd7};
        tbl[8]  = '{8,  1'b1, 4'd8};
        tbl[9]  = '{9,  1'b1, 4'd8};
        tbl[10] = '{10, 1'b1, 4'd8};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_data_o", 32'(data_o), 32'd0);
        check("reset_rd_cnt", 32'(rd_cnt), 32'd0);
        resetn = 1'b1;
        step();
        check("post_reset_data_o", 32'(data_o), 32'd0);

        // Basic read-out sequence, table driven
        btn_pad[7:0] = 8'b1000_0101;
        strobe_pulse();
        begin
            int done;
            done = 0;
            for (int i = 0; i < 11; i++) begin
                while (done < tbl[i].edges) begin
                    pulse_pclk(0);
                    done++;
                end
                check($sformatf("seq_dat_e%0d", tbl[i].edges), 32'(data_o[0]), 32'(tbl[i].dat));
                check($sformatf("seq_cnt_e%0d", tbl[i].edges), 32'(rd_cnt[3:0]), 32'(tbl[i].cnt));
            end
        end

        // Strobe held high: edges ignored, continuous reload
        btn_pad[7:0] = 8'h01;
        strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            port_clk[0] = ~port_clk[0];
            step();
            check("hold_dat", 32'(data_o[0]), 32'd1);
            check("hold_cnt", 32'(rd_cnt[3:0]), 32'd0);
        end
        strobe = 1'b0; port_clk[0] = 1'b0;
        step();

        // Strobe and falling edge in the same cycle: reload wins
        btn_pad[7:0] = 8'h02;
        strobe_pulse();
        pulse_pclk(0);
        pulse_pclk(0);
        check("pre_collide_cnt", 32'(rd_cnt[3:0]), 32'd2);
        port_clk[0] = 1'b1; step();
        port_clk[0] = 1'b0; strobe = 1'b1; step();
        strobe = 1'b0;
        check("collide_dat", 32'(data_o[0]), 32'd0);
        check("collide_cnt", 32'(rd_cnt[3:0]), 32'd0);
        pulse_pclk(0);
        check("after_collide_dat", 32'(data_o[0]), 32'd1);
        check("after_collide_cnt", 32'(rd_cnt[3:0]), 32'd1);

        // Port independence
        btn_pad = {8'hA5, 8'hFF};
        strobe_pulse();
        for (int i = 0; i < 10; i++) begin
            pulse_pclk(1);
            check("indep_p0_dat", 32'(data_o[0]), 32'd1);
            check("indep_p0_cnt", 32'(rd_cnt[3:0]), 32'd0);
            check_model();
        end
        check("indep_p1_cnt", 32'(rd_cnt[7:4]), 32'd8);

        // Reset mid-read
        btn_pad[7:0] = 8'hFF;
        strobe_pulse();
        for (int i = 0; i < 3; i++) pulse_pclk(0);
        check("mid_cnt", 32'(rd_cnt[3:0]), 32'd3);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_dat", 32'(data_o), 32'd0);
        check("async_rst_cnt", 32'(rd_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) pulse_pclk(0);
        check("rst_idle_dat", 32'(data_o[0]), 32'd0);
        check("rst_idle_cnt", 32'(rd_cnt[3:0]), 32'd0);
        strobe_pulse();
        check("rst_restrobe_dat", 32'(data_o[0]), 32'd1);

        // Autofire on port 1 bit 0, strobe held every cycle
        resetn = 1'b0;
        btn_pad = '0; btn_ovr = '0;
        turbo_req = '0; turbo_req[BW] = 1'b1;
        strobe = 1'b1; port_clk = '0;
        @(negedge clk);
        resetn = 1'b1;
        ones = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            check("turbo_dat_p1", 32'(data_o[1]), 32'(exp_dat(1)));
            if (data_o[1] === 1'b1) ones++;
        end
`ifdef JOYPAD_AUTOFIRE_EN
        check("turbo_high_cycles", 32'(ones), 32'd12);
`else
        check("turbo_high_cycles", 32'(ones), 32'd0);
`endif
        strobe = 1'b0;
        step();

        // Randomized traffic against the model
        btn_pad = 16'($urandom);
        strobe_pulse();
        for (int i = 0; i < 400; i++) begin
            strobe   = ($urandom_range(0, 15) == 0);
            port_clk = 2'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                btn_pad   = 16'($urandom);
                btn_ovr   = 16'($urandom) & 16'($urandom);
                turbo_req = 16'($urandom);
            end
            step();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
